// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with selectable bit order and frame resync.
// Completed words wait in a holding register behind a valid/ready handshake.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shQ, shD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [WIDTH-1:0] dataQ, dataD;
  logic             validQ, validD;
  logic             overrunQ, overrunD;

  logic [CNT_W-1:0] cntEff;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             transfer;

  // A frame_start bit restarts the word at position 0, dropping any partial bits.
  always_comb begin
    cntEff = frame_start ? '0 : cntQ;
    if (LSB_FIRST) begin
      shifted = {bit_in, shQ[WIDTH-1:1]};
    end else begin
      shifted = {shQ[WIDTH-2:0], bit_in};
    end
    complete = bit_valid && (cntEff == LAST_IDX);
    transfer = validQ && word_ready;
  end

  always_comb begin
    shD      = shQ;
    cntD     = cntQ;
    dataD    = dataQ;
    validD   = validQ;
    overrunD = overrunQ;

    if (bit_valid) begin
      shD  = shifted;
      cntD = complete ? '0 : cntEff + CNT_W'(1);
    end

    if (transfer) begin
      validD = 1'b0;
    end

    if (clr_overrun) begin
      overrunD = 1'b0;
    end

    // A finished word is only dropped when the holding register is full and not draining.
    if (complete) begin
      if (!validQ || word_ready) begin
        dataD  = shifted;
        validD = 1'b1;
      end else begin
        overrunD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shQ      <= '0;
      cntQ     <= '0;
      dataQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      shQ      <= shD;
      cntQ     <= cntD;
      dataQ    <= dataD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign word_data  = dataQ;
  assign word_valid = validQ;
  assign bit_count  = cntQ;
  assign overrun    = overrunQ;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: table-driven vectors plus
// hand-written multi-cycle sequences, with a queue of expected words.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, bit_valid, bit_in, frame_start, word_ready, clr_overrun;
  logic [7:0] dataM, dataL;
  logic       validM, validL, ovrM, ovrL;
  logic [2:0] cntM, cntL;

  int checks = 0;
  int passes = 0;
  logic [7:0] expQ[$];
  bit useL = 1'b0;

  logic [7:0] selData;
  logic       selValid, selOvr;
  logic [2:0] selCnt;
  assign selData  = useL ? dataL  : dataM;
  assign selValid = useL ? validL : validM;
  assign selOvr   = useL ? ovrL   : ovrM;
  assign selCnt   = useL ? cntL   : cntM;

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .word_data(dataM), .word_valid(validM),
    .word_ready(word_ready), .bit_count(cntM), .overrun(ovrM),
    .clr_overrun(clr_overrun)
  );

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dutL (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .word_data(dataL), .word_valid(validL),
    .word_ready(word_ready), .bit_count(cntL), .overrun(ovrL),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    bit         bv;
    bit         bi;
    bit         fs;
    bit         wr;
    bit         clr;
    logic [2:0] cnt;
    bit         valid;
    bit         ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit bv, input bit bi, input bit fs, input bit wr, input bit clr);
    bit_valid   = bv;
    bit_in      = bi;
    frame_start = fs;
    word_ready  = wr;
    clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic popWord(input string name);
    logic [7:0] exp;
    if (expQ.size() == 0) begin
      checkOutput({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      exp = expQ.pop_front();
      checkOutput(name, selData, exp);
    end
  endtask

  task automatic runTable(input string tag);
    bit prevValid = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].bv, vecs[i].bi, vecs[i].fs, vecs[i].wr, vecs[i].clr);
      checkOutput({tag, "_cnt"}, selCnt, vecs[i].cnt);
      checkOutput({tag, "_valid"}, selValid, vecs[i].valid);
      checkOutput({tag, "_ovr"}, selOvr, vecs[i].ovr);
      if (vecs[i].valid && !prevValid) popWord({tag, "_data"});
      prevValid = vecs[i].valid;
    end
  endtask

  // MSB-first word on the LSB_FIRST=0 instance; ready/clear can differ on the last bit.
  task automatic sendWord(input logic [7:0] w, input bit wrOther, input bit wrLast, input bit clrLast);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, w[7-i], 0, (i == 7) ? wrLast : wrOther, (i == 7) ? clrLast : 1'b0);
      checkOutput("send_cnt", selCnt, 64'((i + 1) % 8));
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] tail;
    pat  = 8'hD0;
    tail = 8'hD0;
    reset = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
    word_ready = 1'b0; clr_overrun = 1'b0;

    // Reset state on both instances
    doReset();
    checkOutput("rst_data", dataM, 64'h0);
    checkOutput("rst_valid", validM, 64'h0);
    checkOutput("rst_cnt", cntM, 64'h0);
    checkOutput("rst_ovr", ovrM, 64'h0);
    checkOutput("rst_dataL", dataL, 64'h0);

    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, pat[7-i], 1'b0, 1'b1, 1'b0, 3'((i + 1) % 8), (i == 7), 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});

    // MSB-first word
    useL = 1'b0;
    expQ.push_back(8'hD0);
    runTable("msb");
    checkOutput("msb_hold_data", dataM, 64'hD0);

    // LSB-first word from the same stream
    doReset();
    useL = 1'b1;
    expQ.push_back(8'h0B);
    runTable("lsb");
    useL = 1'b0;

    // Gapped stream with junk on bit_in/frame_start while idle
    doReset();
    expQ.push_back(8'hD0);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        checkOutput("gap_cnt", cntM, 64'(i));
      end
      applyStimulus(1, pat[7-i], 0, 1, 0);
    end
    checkOutput("gap_valid", validM, 64'h1);
    popWord("gap_data");

    // Stalled consumer: overrun, drain, clear, set-beats-clear
    doReset();
    sendWord(8'hD0, 0, 0, 0);
    checkOutput("stall_valid1", validM, 64'h1);
    checkOutput("stall_data1", dataM, 64'hD0);
    checkOutput("stall_ovr1", ovrM, 64'h0);
    sendWord(8'h5A, 0, 0, 0);
    checkOutput("ovr_valid", validM, 64'h1);
    checkOutput("ovr_data", dataM, 64'hD0);
    checkOutput("ovr_set", ovrM, 64'h1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("drain_valid", validM, 64'h0);
    checkOutput("drain_ovr", ovrM, 64'h1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_ovr", ovrM, 64'h0);
    sendWord(8'hD0, 0, 0, 0);
    checkOutput("reload_data", dataM, 64'hD0);
    sendWord(8'h5A, 0, 0, 1);
    checkOutput("set_wins_ovr", ovrM, 64'h1);
    checkOutput("set_wins_data", dataM, 64'hD0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_ovr2", ovrM, 64'h0);

    // Transfer and completion on the same edge
    doReset();
    sendWord(8'hD0, 0, 0, 0);
    expQ.push_back(8'h5A);
    sendWord(8'h5A, 0, 1, 0);
    popWord("same_edge_data");
    checkOutput("same_edge_valid", validM, 64'h1);
    checkOutput("same_edge_ovr", ovrM, 64'h0);

    // frame_start discards a partial word
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 0);
      checkOutput("partial_cnt", cntM, 64'(i + 1));
    end
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("resync_cnt", cntM, 64'h1);
    expQ.push_back(8'hD0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1, tail[7-i], 0, 1, 0);
      checkOutput("resync_tail_cnt", cntM, 64'((i + 1) % 8));
    end
    checkOutput("resync_valid", validM, 64'h1);
    popWord("resync_data");

    // Mid-word reset wipes pending word, overrun and partial bits
    doReset();
    sendWord(8'hD0, 0, 0, 0);
    sendWord(8'h5A, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("pre_rst_cnt", cntM, 64'h5);
    checkOutput("pre_rst_ovr", ovrM, 64'h1);
    reset = 1'b1;
    applyStimulus(1, 1, 1, 1, 0);
    reset = 1'b0;
    checkOutput("midrst_data", dataM, 64'h0);
    checkOutput("midrst_valid", validM, 64'h0);
    checkOutput("midrst_cnt", cntM, 64'h0);
    checkOutput("midrst_ovr", ovrM, 64'h0);
    expQ.push_back(8'h5A);
    sendWord(8'h5A, 1, 1, 0);
    checkOutput("post_rst_valid", validM, 64'h1);
    popWord("post_rst_data");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
